multicycle_control: RTL and testbench
=====================================

// Module: multicycle_control
// PURPOSE
//  Main sequencer for the multi-cycle MIPS32 datapath (shared ALU, single memory port, IR/MDR/A/B/ALUOut regs).
//  Walks each instruction through fetch/decode/execute/mem/writeback states and drives all datapath selects and enables.
//  Drives ALU op codes, and waits on a memory ready handshake with a bounded timeout.
//  Supported: R-type (add/sub/and/or/nor/slt), lw, sw, beq, addi, j.
// PARAMETERS
//  TIMEOUT_CYCLES  255  max cycles to wait for mem_ready in a memory state before aborting (1..255)
// PORTS
//  clk          in   1  rising-edge clock
//  reset_n      in   1  asynchronous active-low reset
//  opcode       in   6  IR[31:26], valid from DECODE onward
//  func_field   in   6  IR[5:0]
//  zero         in   1  ALU zero flag (combinational, same cycle)
//  mem_ready    in   1  memory has completed the current read/write this cycle
//  mem_read     out  1  memory read request
//  mem_write    out  1  memory write request
//  iord         out  1  0: address=PC, 1: address=ALUOut
//  ir_write     out  1  load IR (only in the FETCH cycle where mem_ready=1)
//  pc_en        out  1  PC write enable = pc_write | (pc_write_cond & zero)
//  pc_source    out  2  0: ALU result, 1: ALUOut, 2: {PC[31:28],IR[25:0],2'b00}
//  alu_src_a    out  1  0: PC, 1: reg A
//  alu_src_b    out  2  0: reg B, 1: const 4, 2: sext(imm), 3: sext(imm)<<2
//  alu_control  out  3  0 add, 1 sub, 2 and, 3 or, 4 nor, 5 slt
//  reg_dst      out  1  0: rt, 1: rd
//  mem_to_reg   out  1  0: ALUOut, 1: MDR
//  reg_write    out  1  register-file write enable
//  instr_done   out  1  one-cycle pulse in the last state of each instruction
//  illegal_op   out  1  one-cycle pulse; unsupported opcode seen in DECODE
//  mem_timeout  out  1  one-cycle pulse; wait counter hit TIMEOUT_CYCLES
// BEHAVIOUR
//  - Reset: state=IDLE and wait counter=0 asynchronously. All outputs are 0 while in IDLE. IDLE->FETCH on the next clk.
//  - Outputs are Moore (decoded from state) except pc_en (uses zero) and ir_write/instr_done (gated by mem_ready).
//  - FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=1, alu_control=add, pc_source=0.
//    Stays in FETCH until mem_ready=1. In that cycle: ir_write=1, pc_write=1, next state is DECODE.
//  - DECODE: alu_src_a=0, alu_src_b=3, add (branch target into ALUOut). Next state by opcode:
//    0x00->EXEC, 0x23/0x2B->MEMADR, 0x04->BRANCH, 0x08->ADDIEX, 0x02->JUMP.
//    Any other opcode: illegal_op=1 and next state is FETCH.
//  - EXEC: alu_src_a=1, alu_src_b=0, alu_control from func_field
//    (0x20->0, 0x22->1, 0x24->2, 0x25->3, 0x27->4, 0x2A->5, other->0). Next state ALUWB.
//  - ALUWB: reg_dst=1, mem_to_reg=0, reg_write=1, instr_done=1; next state FETCH.
//  - MEMADR: alu_src_a=1, alu_src_b=2, add; next state MEMRD (lw) or MEMWR (sw).
//  - MEMRD: mem_read=1, iord=1. Wait for mem_ready, then go to MEMWB.
//    MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1, instr_done=1; next state FETCH.
//  - MEMWR: mem_write=1, iord=1. Wait for mem_ready. In that cycle instr_done=1 and next state is FETCH.
//  - BRANCH: alu_src_a=1, alu_src_b=0, sub, pc_write_cond=1, pc_source=1, instr_done=1; next state FETCH.
//  - ADDIEX: alu_src_a=1, alu_src_b=2, add; next state ADDIWB.
//    ADDIWB: reg_dst=0, mem_to_reg=0, reg_write=1, instr_done=1; next state FETCH.
//  - JUMP: pc_write=1, pc_source=2, instr_done=1; next state FETCH.
//  - Wait counter (8 bits):
//    - clears on entry to FETCH/MEMRD/MEMWR and whenever mem_ready=1; otherwise increments each wait cycle.
//    - When it reaches TIMEOUT_CYCLES: mem_timeout=1, request dropped, next state IDLE.
//    - No IR/PC/register write occurs on timeout.
//  - mem_ready outside FETCH/MEMRD/MEMWR is ignored.
//  - reset_n low mid-instruction: immediate abort to IDLE; no partial write is completed.
//  - State encoding is 4 bits; unreachable codes go to IDLE next cycle.
// STRUCTURE
//  - Package mips_ctrl_pkg holds: state enum (IDLE, FETCH, DECODE, EXEC, ALUWB, MEMADR, MEMRD, MEMWB, MEMWR,
//    BRANCH, ADDIEX, ADDIWB, JUMP); opcode constants; funct constants; ALU op codes 0..5; alu_src_b/pc_source encodings.
//  - Sub-module funct_alu_decode: combinational func_field->3-bit ALU op, instantiated for the EXEC state.
//  - Top level holds the state register, wait counter, next-state logic and output decode.
// TESTING
//  - Reset, then mem_ready=1 always, opcode=0x00, func=0x22: states IDLE,FETCH,DECODE,EXEC,ALUWB.
//    EXEC alu_control=1; ALUWB reg_write=1, reg_dst=1, instr_done=1.
//  - lw (0x23) with mem_ready low 3 cycles in MEMRD: MEMRD held 4 cycles, mem_read=1, iord=1;
//    then MEMWB with mem_to_reg=1. Total 4+1+1+4+1=11 cycles from FETCH.
//  - beq (0x04): zero=1 -> pc_en=1, pc_source=1 in BRANCH; zero=0 -> pc_en=0. Both return to FETCH.
//  - Opcode 0x3F in DECODE -> illegal_op pulses 1 cycle, next state FETCH, reg_write/mem_write never asserted.
//  - TIMEOUT_CYCLES=4, mem_ready held 0 in FETCH -> mem_timeout pulses in the 5th FETCH cycle,
//    state IDLE next, ir_write never 1.
//  - reset_n dropped mid-MEMWR -> mem_write falls immediately (async), state IDLE. After release: IDLE then FETCH.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS32 control sequencer.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        FETCH  = 4'd1,
        DECODE = 4'd2,
        EXEC   = 4'd3,
        ALUWB  = 4'd4,
        MEMADR = 4'd5,
        MEMRD  = 4'd6,
        MEMWB  = 4'd7,
        MEMWR  = 4'd8,
        BRANCH = 4'd9,
        ADDIEX = 4'd10,
        ADDIWB = 4'd11,
        JUMP   = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_NOR = 3'd4;
    localparam logic [2:0] ALU_SLT = 3'd5;

    localparam logic [1:0] SRCB_REG    = 2'd0;
    localparam logic [1:0] SRCB_FOUR   = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH = 2'd3;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    // States that sit on the memory handshake and are subject to the timeout.
    function automatic logic is_wait_state(input state_t s);
        return (s == FETCH) || (s == MEMRD) || (s == MEMWR);
    endfunction

endpackage

// File: rtl/funct_alu_decode.sv
// Maps the R-type funct field to the 3-bit ALU operation; unknown functs fall back to add.
module funct_alu_decode
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] func_field,
    output logic [2:0] alu_op
);

    // funct -> ALU op lookup
    always_comb begin
        alu_op = ALU_ADD;
        case (func_field)
            FN_ADD:  alu_op = ALU_ADD;
            FN_SUB:  alu_op = ALU_SUB;
            FN_AND:  alu_op = ALU_AND;
            FN_OR:   alu_op = ALU_OR;
            FN_NOR:  alu_op = ALU_NOR;
            FN_SLT:  alu_op = ALU_SLT;
            default: alu_op = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Main sequencer for the multi-cycle MIPS32 datapath: state register, memory wait counter,
// next-state logic and datapath control decode.
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] opcode,
    input  logic [5:0] func_field,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_read,
    output logic       mem_write,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_en,
    output logic [1:0] pc_source,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_control,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       instr_done,
    output logic       illegal_op,
    output logic       mem_timeout
);

    localparam logic [7:0] TIMEOUT_C = TIMEOUT_CYCLES[7:0];

    state_t     state_r;
    state_t     state_next_s;
    logic [7:0] wait_cnt_r;
    logic [2:0] exec_alu_op_s;
    logic       wait_state_s;
    logic       timeout_hit_s;
    logic       pc_write_s;
    logic       pc_write_cond_s;

    funct_alu_decode u_funct_alu_decode (
        .func_field (func_field),
        .alu_op     (exec_alu_op_s)
    );

    assign wait_state_s  = is_wait_state(state_r);
    assign timeout_hit_s = wait_state_s && !mem_ready && (wait_cnt_r == TIMEOUT_C);

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Wait counter: restarts on every state change or completed handshake
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt_r <= 8'd0;
        end else if ((state_next_s != state_r) || mem_ready) begin
            wait_cnt_r <= 8'd0;
        end else if (wait_state_s) begin
            wait_cnt_r <= wait_cnt_r + 8'd1;
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end

    // Next-state and control decode
    always_comb begin
        state_next_s    = state_r;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        iord            = 1'b0;
        ir_write        = 1'b0;
        pc_write_s      = 1'b0;
        pc_write_cond_s = 1'b0;
        pc_source       = PCSRC_ALU;
        alu_src_a       = 1'b0;
        alu_src_b       = SRCB_REG;
        alu_control     = ALU_ADD;
        reg_dst         = 1'b0;
        mem_to_reg      = 1'b0;
        reg_write       = 1'b0;
        instr_done      = 1'b0;
        illegal_op      = 1'b0;
        mem_timeout     = 1'b0;
        case (state_r)
            IDLE: state_next_s = FETCH;
            FETCH: begin
                alu_src_b = SRCB_FOUR;
                if (timeout_hit_s) begin
                    mem_timeout  = 1'b1;
                    state_next_s = IDLE;
                end else begin
                    mem_read = 1'b1;
                    if (mem_ready) begin
                        ir_write     = 1'b1;
                        pc_write_s   = 1'b1;
                        state_next_s = DECODE;
                    end else begin
                        state_next_s = FETCH;
                    end
                end
            end
            DECODE: begin
                alu_src_b = SRCB_IMM_SH;
                case (opcode)
                    OP_RTYPE:    state_next_s = EXEC;
                    OP_LW, OP_SW: state_next_s = MEMADR;
                    OP_BEQ:      state_next_s = BRANCH;
                    OP_ADDI:     state_next_s = ADDIEX;
                    OP_J:        state_next_s = JUMP;
                    default: begin
                        illegal_op   = 1'b1;
                        state_next_s = FETCH;
                    end
                endcase
            end
            EXEC: begin
                alu_src_a    = 1'b1;
                alu_control  = exec_alu_op_s;
                state_next_s = ALUWB;
            end
            ALUWB: begin
                reg_dst      = 1'b1;
                reg_write    = 1'b1;
                instr_done   = 1'b1;
                state_next_s = FETCH;
            end
            MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                if (opcode == OP_LW) begin
                    state_next_s = MEMRD;
                end else begin
                    state_next_s = MEMWR;
                end
            end
            MEMRD: begin
                iord = 1'b1;
                if (timeout_hit_s) begin
                    mem_timeout  = 1'b1;
                    state_next_s = IDLE;
                end else begin
                    mem_read = 1'b1;
                    if (mem_ready) begin
                        state_next_s = MEMWB;
                    end else begin
                        state_next_s = MEMRD;
                    end
                end
            end
            MEMWB: begin
                mem_to_reg   = 1'b1;
                reg_write    = 1'b1;
                instr_done   = 1'b1;
                state_next_s = FETCH;
            end
            MEMWR: begin
                iord = 1'b1;
                if (timeout_hit_s) begin
                    mem_timeout  = 1'b1;
                    state_next_s = IDLE;
                end else begin
                    mem_write = 1'b1;
                    if (mem_ready) begin
                        instr_done   = 1'b1;
                        state_next_s = FETCH;
                    end else begin
                        state_next_s = MEMWR;
                    end
                end
            end
            BRANCH: begin
                alu_src_a       = 1'b1;
                alu_control     = ALU_SUB;
                pc_write_cond_s = 1'b1;
                pc_source       = PCSRC_ALUOUT;
                instr_done      = 1'b1;
                state_next_s    = FETCH;
            end
            ADDIEX: begin
                alu_src_a    = 1'b1;
                alu_src_b    = SRCB_IMM;
                state_next_s = ADDIWB;
            end
            ADDIWB: begin
                reg_write    = 1'b1;
                instr_done   = 1'b1;
                state_next_s = FETCH;
            end
            JUMP: begin
                pc_write_s   = 1'b1;
                pc_source    = PCSRC_JUMP;
                instr_done   = 1'b1;
                state_next_s = FETCH;
            end
            default: state_next_s = IDLE;
        endcase
        pc_en = pc_write_s | (pc_write_cond_s & zero);
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed, table-driven bench for multicycle_control (timeout shortened to 4 cycles).
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [5:0] opcode;
    logic [5:0] func_field;
    logic       zero;
    logic       mem_ready;
    logic       mem_read, mem_write, iord, ir_write, pc_en;
    logic [1:0] pc_source, alu_src_b;
    logic       alu_src_a;
    logic [2:0] alu_control;
    logic       reg_dst, mem_to_reg, reg_write, instr_done, illegal_op, mem_timeout;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    multicycle_control #(.TIMEOUT_CYCLES(4)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .opcode      (opcode),
        .func_field  (func_field),
        .zero        (zero),
        .mem_ready   (mem_ready),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .iord        (iord),
        .ir_write    (ir_write),
        .pc_en       (pc_en),
        .pc_source   (pc_source),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .alu_control (alu_control),
        .reg_dst     (reg_dst),
        .mem_to_reg  (mem_to_reg),
        .reg_write   (reg_write),
        .instr_done  (instr_done),
        .illegal_op  (illegal_op),
        .mem_timeout (mem_timeout)
    );

    // Output vector layout, MSB first:
    // mem_read mem_write iord ir_write pc_en pc_source[1:0] alu_src_a alu_src_b[1:0]
    // alu_control[2:0] reg_dst mem_to_reg reg_write instr_done illegal_op mem_timeout
    logic [18:0] act;
    assign act = {mem_read, mem_write, iord, ir_write, pc_en, pc_source, alu_src_a, alu_src_b,
                  alu_control, reg_dst, mem_to_reg, reg_write, instr_done, illegal_op, mem_timeout};

    localparam logic [18:0] B_MR   = 19'd1 << 18;
    localparam logic [18:0] B_MW   = 19'd1 << 17;
    localparam logic [18:0] B_IORD = 19'd1 << 16;
    localparam logic [18:0] B_IRW  = 19'd1 << 15;
    localparam logic [18:0] B_PCEN = 19'd1 << 14;
    localparam logic [18:0] B_PCS1 = 19'd1 << 12;
    localparam logic [18:0] B_PCS2 = 19'd2 << 12;
    localparam logic [18:0] B_ASA  = 19'd1 << 11;
    localparam logic [18:0] B_ASB1 = 19'd1 << 9;
    localparam logic [18:0] B_ASB2 = 19'd2 << 9;
    localparam logic [18:0] B_ASB3 = 19'd3 << 9;
    localparam logic [18:0] B_RD   = 19'd1 << 5;
    localparam logic [18:0] B_M2R  = 19'd1 << 4;
    localparam logic [18:0] B_RW   = 19'd1 << 3;
    localparam logic [18:0] B_DONE = 19'd1 << 2;
    localparam logic [18:0] B_ILL  = 19'd1 << 1;
    localparam logic [18:0] B_TO   = 19'd1;

    localparam logic [18:0] E_IDLE       = 19'd0;
    localparam logic [18:0] E_FETCH_OK   = B_MR | B_IRW | B_PCEN | B_ASB1;
    localparam logic [18:0] E_FETCH_WAIT = B_MR | B_ASB1;
    localparam logic [18:0] E_FETCH_TO   = B_ASB1 | B_TO;
    localparam logic [18:0] E_DECODE     = B_ASB3;
    localparam logic [18:0] E_DECODE_ILL = B_ASB3 | B_ILL;
    localparam logic [18:0] E_ALUWB      = B_RD | B_RW | B_DONE;
    localparam logic [18:0] E_MEMADR     = B_ASA | B_ASB2;
    localparam logic [18:0] E_MEMRD      = B_MR | B_IORD;
    localparam logic [18:0] E_MEMWB      = B_M2R | B_RW | B_DONE;
    localparam logic [18:0] E_MEMWR_WAIT = B_MW | B_IORD;
    localparam logic [18:0] E_MEMWR_OK   = B_MW | B_IORD | B_DONE;
    localparam logic [18:0] E_BRANCH     = B_PCS1 | B_ASA | (19'd1 << 6) | B_DONE;
    localparam logic [18:0] E_ADDIEX     = B_ASA | B_ASB2;
    localparam logic [18:0] E_ADDIWB     = B_RW | B_DONE;
    localparam logic [18:0] E_JUMP       = B_PCEN | B_PCS2 | B_DONE;

    function automatic logic [18:0] e_exec(input logic [2:0] op);
        return B_ASA | {10'd0, op, 6'd0};
    endfunction

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        z;
        logic        rdy;
        logic [18:0] exp;
        string       tag;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input logic rdy, input logic [18:0] exp, input string tag);
        vec_t v;
        v.op = op; v.fn = fn; v.z = z; v.rdy = rdy; v.exp = exp; v.tag = tag;
        tbl.push_back(v);
    endtask

    task automatic check(input string tag, input logic [18:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: outputs got %05h expected %05h", tag, act, exp);
        end
    endtask

    logic [5:0] fn_list [7] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h3F};
    logic [2:0] op_list [7] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0};

    initial begin
        reset_n = 1'b1; opcode = 6'h00; func_field = 6'h00; zero = 1'b0; mem_ready = 1'b1;

        // R-type sweep over every funct plus an unknown one
        add(6'h00, 6'h00, 1'b0, 1'b1, E_IDLE, "idle_after_reset");
        for (int i = 0; i < 7; i++) begin
            add(6'h00, fn_list[i], 1'b0, 1'b1, E_FETCH_OK, "r_fetch");
            add(6'h00, fn_list[i], 1'b0, 1'b1, E_DECODE, "r_decode");
            add(6'h00, fn_list[i], 1'b0, 1'b1, e_exec(op_list[i]), "r_exec");
            add(6'h00, fn_list[i], 1'b0, 1'b1, E_ALUWB, "r_aluwb");
        end
        // lw with 3 wait cycles in FETCH and in MEMRD: 11 cycles
        for (int i = 0; i < 3; i++) add(6'h23, 6'h00, 1'b0, 1'b0, E_FETCH_WAIT, "lw_fetch_wait");
        add(6'h23, 6'h00, 1'b0, 1'b1, E_FETCH_OK, "lw_fetch");
        add(6'h23, 6'h00, 1'b0, 1'b1, E_DECODE, "lw_decode");
        add(6'h23, 6'h00, 1'b0, 1'b1, E_MEMADR, "lw_memadr");
        for (int i = 0; i < 3; i++) add(6'h23, 6'h00, 1'b0, 1'b0, E_MEMRD, "lw_memrd_wait");
        add(6'h23, 6'h00, 1'b0, 1'b1, E_MEMRD, "lw_memrd_ready");
        add(6'h23, 6'h00, 1'b0, 1'b1, E_MEMWB, "lw_memwb");
        // sw with one wait cycle
        add(6'h2B, 6'h00, 1'b0, 1'b1, E_FETCH_OK, "sw_fetch");
        add(6'h2B, 6'h00, 1'b0, 1'b1, E_DECODE, "sw_decode");
        add(6'h2B, 6'h00, 1'b0, 1'b1, E_MEMADR, "sw_memadr");
        add(6'h2B, 6'h00, 1'b0, 1'b0, E_MEMWR_WAIT, "sw_memwr_wait");
        add(6'h2B, 6'h00, 1'b0, 1'b1, E_MEMWR_OK, "sw_memwr_ready");
        // beq taken / not taken; zero in DECODE must not move the PC
        add(6'h04, 6'h00, 1'b1, 1'b1, E_FETCH_OK, "beq_t_fetch");
        add(6'h04, 6'h00, 1'b1, 1'b1, E_DECODE, "beq_t_decode");
        add(6'h04, 6'h00, 1'b1, 1'b1, E_BRANCH | B_PCEN, "beq_taken");
        add(6'h04, 6'h00, 1'b0, 1'b1, E_FETCH_OK, "beq_n_fetch");
        add(6'h04, 6'h00, 1'b0, 1'b1, E_DECODE, "beq_n_decode");
        add(6'h04, 6'h00, 1'b0, 1'b1, E_BRANCH, "beq_not_taken");
        // addi and j
        add(6'h08, 6'h00, 1'b0, 1'b1, E_FETCH_OK, "addi_fetch");
        add(6'h08, 6'h00, 1'b0, 1'b1, E_DECODE, "addi_decode");
        add(6'h08, 6'h00, 1'b0, 1'b1, E_ADDIEX, "addi_ex");
        add(6'h08, 6'h00, 1'b0, 1'b1, E_ADDIWB, "addi_wb");
        add(6'h02, 6'h00, 1'b0, 1'b1, E_FETCH_OK, "j_fetch");
        add(6'h02, 6'h00, 1'b0, 1'b1, E_DECODE, "j_decode");
        add(6'h02, 6'h00, 1'b0, 1'b1, E_JUMP, "j_jump");
        // illegal opcode returns to FETCH
        add(6'h3F, 6'h00, 1'b0, 1'b1, E_FETCH_OK, "ill_fetch");
        add(6'h3F, 6'h00, 1'b0, 1'b1, E_DECODE_ILL, "ill_decode");
        // FETCH timeout: 4 waits, timeout in the 5th cycle, then IDLE, FETCH
        for (int i = 0; i < 4; i++) add(6'h3F, 6'h00, 1'b0, 1'b0, E_FETCH_WAIT, "to_fetch_wait");
        add(6'h3F, 6'h00, 1'b0, 1'b0, E_FETCH_TO, "to_timeout");
        add(6'h2B, 6'h00, 1'b0, 1'b1, E_IDLE, "to_idle");
        // sw again, parked in MEMWR for the reset test
        add(6'h2B, 6'h00, 1'b0, 1'b1, E_FETCH_OK, "sw2_fetch");
        add(6'h2B, 6'h00, 1'b0, 1'b1, E_DECODE, "sw2_decode");
        add(6'h2B, 6'h00, 1'b0, 1'b1, E_MEMADR, "sw2_memadr");
        add(6'h2B, 6'h00, 1'b0, 1'b0, E_MEMWR_WAIT, "sw2_memwr_wait");

        #2 reset_n = 1'b0;
        @(negedge clk);
        check("reset_state", E_IDLE);
        @(posedge clk);
        @(posedge clk); #1;
        reset_n = 1'b1;

        foreach (tbl[i]) begin
            opcode = tbl[i].op; func_field = tbl[i].fn; zero = tbl[i].z; mem_ready = tbl[i].rdy;
            @(negedge clk);
            check(tbl[i].tag, tbl[i].exp);
            @(posedge clk); #1;
        end

        // Asynchronous reset in the middle of a store
        mem_ready = 1'b0;
        @(negedge clk);
        check("memwr_before_reset", E_MEMWR_WAIT);
        #2 reset_n = 1'b0;
        #1 check("async_reset_abort", E_IDLE);
        @(posedge clk); #1;
        check("held_in_reset", E_IDLE);
        reset_n = 1'b1;
        mem_ready = 1'b1;
        @(negedge clk);
        check("idle_after_release", E_IDLE);
        @(posedge clk); #1;
        @(negedge clk);
        check("fetch_after_release", E_FETCH_OK);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
